// File: rtl/zbt_point_writer.sv
// Bursts point-table records into ZBT SRAM, yielding every contended cycle to display reads.
// Models the 2-cycle ZBT pipeline for both write data and read capture.
module zbt_point_writer #(
  parameter int unsigned N_ENTRIES = 8,
  parameter int unsigned AW        = 19,
  parameter int unsigned DW        = 36
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  output logic          busy,
  output logic          done,
  output logic [2:0]    tbl_index,
  input  logic [DW-1:0] tbl_value,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_grant,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic [AW-1:0] zbt_addr,
  output logic          zbt_we_n,
  output logic [DW-1:0] zbt_wdata,
  output logic          zbt_drive,
  input  logic [DW-1:0] zbt_rdata
);

  localparam int unsigned IW = 3;
  localparam int unsigned CW = 2;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DRAIN, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [AW-1:0] base_q, base_d;
  logic [CW-1:0] drain_q, drain_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [AW-1:0] zbt_addr_q, zbt_addr_d;
  logic          zbt_we_n_q, zbt_we_n_d;
  logic [DW-1:0] s1_data_q, s1_data_d;
  logic          s1_vld_q, s1_vld_d;
  logic [DW-1:0] s2_data_q, s2_data_d;
  logic          s2_vld_q, s2_vld_d;
  logic [DW-1:0] zbt_wdata_q, zbt_wdata_d;
  logic          zbt_drive_q, zbt_drive_d;
  logic          rv1_q, rv1_d;
  logic          rv2_q, rv2_d;
  logic          rd_valid_q, rd_valid_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          issue;

  assign rd_grant  = rd_req;
  assign issue     = (state_q == S_WRITE) && !rd_req;
  assign busy      = busy_q;
  assign done      = done_q;
  assign tbl_index = idx_q;
  assign zbt_addr  = zbt_addr_q;
  assign zbt_we_n  = zbt_we_n_q;
  assign zbt_wdata = zbt_wdata_q;
  assign zbt_drive = zbt_drive_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;

  // Next-state: port arbitration, data pipelines and burst sequencing
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    base_d      = base_q;
    drain_d     = drain_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    zbt_addr_d  = zbt_addr_q;
    zbt_we_n_d  = 1'b1;
    s1_data_d   = s1_data_q;
    s1_vld_d    = 1'b0;
    s2_data_d   = s1_data_q;
    s2_vld_d    = s1_vld_q;
    zbt_wdata_d = zbt_wdata_q;
    zbt_drive_d = s2_vld_q;
    rv1_d       = 1'b0;
    rv2_d       = rv1_q;
    rd_valid_d  = rv2_q;
    rd_data_d   = rd_data_q;

    if (s2_vld_q) zbt_wdata_d = s2_data_q;
    if (rv2_q)    rd_data_d   = zbt_rdata;

    // Each address cycle owns exactly one data cycle two clocks later
    if (rd_req) begin
      zbt_addr_d = rd_addr;
      rv1_d      = 1'b1;
    end else if (issue) begin
      zbt_addr_d = AW'(base_q + AW'(idx_q));
      zbt_we_n_d = 1'b0;
      s1_data_d  = tbl_value;
      s1_vld_d   = 1'b1;
      idx_d      = IW'(idx_q + IW'(1));
    end

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start && !busy_q) begin
          base_d  = base_addr;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (issue && (idx_q == IW'(N_ENTRIES - 1))) begin
          drain_d = CW'(2);
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_q == CW'(1)) state_d = S_DONE;
        else                   drain_d = CW'(drain_q - CW'(1));
      end
      S_DONE: begin
        done_d  = 1'b1;
        idx_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      base_q      <= '0;
      drain_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      zbt_addr_q  <= '0;
      zbt_we_n_q  <= 1'b1;
      s1_data_q   <= '0;
      s1_vld_q    <= 1'b0;
      s2_data_q   <= '0;
      s2_vld_q    <= 1'b0;
      zbt_wdata_q <= '0;
      zbt_drive_q <= 1'b0;
      rv1_q       <= 1'b0;
      rv2_q       <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      base_q      <= base_d;
      drain_q     <= drain_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      zbt_addr_q  <= zbt_addr_d;
      zbt_we_n_q  <= zbt_we_n_d;
      s1_data_q   <= s1_data_d;
      s1_vld_q    <= s1_vld_d;
      s2_data_q   <= s2_data_d;
      s2_vld_q    <= s2_vld_d;
      zbt_wdata_q <= zbt_wdata_d;
      zbt_drive_q <= zbt_drive_d;
      rv1_q       <= rv1_d;
      rv2_q       <= rv2_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

endmodule

// File: tb/tb_zbt_point_writer.sv
// Self-checking bench for zbt_point_writer: an edge-scheduled behavioural model
// plus directed and randomized bursts with read contention.
module tb_zbt_point_writer;
  localparam int unsigned AW = 19;
  localparam int unsigned DW = 36;
  localparam int N = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          busy, done;
  logic [2:0]    tbl_index;
  logic [DW-1:0] tbl_value;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_grant, rd_valid;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] zbt_addr;
  logic          zbt_we_n;
  logic [DW-1:0] zbt_wdata;
  logic          zbt_drive;
  logic [DW-1:0] zbt_rdata = '0;

  logic [DW-1:0] tbl [N];
  assign tbl_value = tbl[tbl_index];

  zbt_point_writer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .busy(busy), .done(done), .tbl_index(tbl_index), .tbl_value(tbl_value),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_grant(rd_grant), .rd_valid(rd_valid),
    .rd_data(rd_data), .zbt_addr(zbt_addr), .zbt_we_n(zbt_we_n),
    .zbt_wdata(zbt_wdata), .zbt_drive(zbt_drive), .zbt_rdata(zbt_rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model state: outputs are scheduled against absolute edge numbers
  int            cyc = 0;
  int            m_idx = N;
  logic [AW-1:0] m_base = '0;
  int            done_edge = -1;
  logic [DW-1:0] wdata_at [int];
  bit            rv_at [int];
  logic [AW-1:0] e_addr = '0;
  logic          e_we_n = 1'b1, e_drive = 1'b0, e_rd_valid = 1'b0, e_done = 1'b0, e_busy = 1'b0;
  logic [DW-1:0] e_wdata = '0, e_rd_data = '0;

  logic          s_start, s_rd_req;
  logic [AW-1:0] s_base, s_rd_addr;
  logic [DW-1:0] s_rdata;

  // Per-burst observations
  logic [AW-1:0] waddrs [$];
  int            done_cnt, done_cyc, start_cyc, rv_cnt, first_addr_cyc, first_drive_cyc;
  logic [DW-1:0] first_wdata;
  bit            alt_mode = 1'b0;

  task automatic model_reset();
    m_idx = N; done_edge = -1;
    wdata_at.delete(); rv_at.delete();
    e_addr = '0; e_we_n = 1'b1; e_drive = 1'b0; e_rd_valid = 1'b0;
    e_done = 1'b0; e_busy = 1'b0; e_wdata = '0; e_rd_data = '0;
  endtask

  task automatic model_edge();
    int  t;
    bit  prev_busy;
    t = cyc;
    prev_busy = e_busy;
    e_done = (t == done_edge);
    e_we_n = 1'b1;
    if (s_rd_req) begin
      e_addr = s_rd_addr;
      rv_at[t+2] = 1'b1;
    end else if (prev_busy && m_idx < N) begin
      e_addr = AW'(m_base + AW'(m_idx));
      e_we_n = 1'b0;
      wdata_at[t+2] = tbl[m_idx];
      m_idx++;
      if (m_idx == N) done_edge = t + 3;
    end
    if (done_edge >= 0 && t == done_edge + 1) e_busy = 1'b0;
    if (s_start && !prev_busy) begin
      e_busy = 1'b1; m_base = s_base; m_idx = 0;
    end
    e_drive = wdata_at.exists(t);
    if (e_drive) begin e_wdata = wdata_at[t]; wdata_at.delete(t); end
    e_rd_valid = rv_at.exists(t);
    if (e_rd_valid) begin e_rd_data = s_rdata; rv_at.delete(t); end
  endtask

  // One clock: snapshot inputs, advance model at the edge, compare #1 later
  task automatic step();
    zbt_rdata = {6'b0, 30'($urandom())};
    #1;
    chk("rd_grant", 64'(rd_grant), 64'(rd_req));
    s_start = start; s_rd_req = rd_req; s_base = base_addr;
    s_rd_addr = rd_addr; s_rdata = zbt_rdata;
    @(posedge clk);
    #1;
    cyc++;
    model_edge();
    chk("zbt_addr", 64'(zbt_addr), 64'(e_addr));
    chk("zbt_we_n", 64'(zbt_we_n), 64'(e_we_n));
    chk("zbt_drive", 64'(zbt_drive), 64'(e_drive));
    chk("zbt_wdata", 64'(zbt_wdata), 64'(e_wdata));
    chk("rd_valid", 64'(rd_valid), 64'(e_rd_valid));
    chk("rd_data", 64'(rd_data), 64'(e_rd_data));
    chk("done", 64'(done), 64'(e_done));
    chk("busy", 64'(busy), 64'(e_busy));
    chk("tbl_index", 64'(tbl_index), 64'(m_idx % N));
    if (alt_mode) chk("no_collide", 64'(zbt_drive & rd_valid), 64'(0));
    if (!zbt_we_n) begin
      if (waddrs.size() == 0) first_addr_cyc = cyc;
      waddrs.push_back(zbt_addr);
    end
    if (zbt_drive && first_drive_cyc < 0) begin first_drive_cyc = cyc; first_wdata = zbt_wdata; end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (rd_valid) rv_cnt++;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_we_n", 64'(zbt_we_n), 64'(1));
    chk("rst_addr", 64'(zbt_addr), 64'(0));
    chk("rst_wdata", 64'(zbt_wdata), 64'(0));
    chk("rst_drive", 64'(zbt_drive), 64'(0));
    chk("rst_rd_valid", 64'(rd_valid), 64'(0));
    chk("rst_rd_data", 64'(rd_data), 64'(0));
    chk("rst_index", 64'(tbl_index), 64'(0));
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic clear_obs();
    waddrs.delete();
    done_cnt = 0; done_cyc = -1; rv_cnt = 0;
    first_addr_cyc = -1; first_drive_cyc = -1; first_wdata = '0;
  endtask

  task automatic rand_table();
    for (int i = 0; i < N; i++) tbl[i] = {6'b0, 30'($urandom())};
  endtask

  // Full burst; stall_after>=0 holds rd_req for 3 cycles once that many writes issued
  task automatic burst(input logic [AW-1:0] b, input int rd_pct, input bit alt,
                       input bit poke, input int stall_after);
    int stalls;
    stalls = 0;
    clear_obs();
    alt_mode = alt;
    base_addr = b; start = 1'b1; start_cyc = cyc + 1;
    step();
    start = 1'b0; base_addr = AW'($urandom());
    for (int i = 0; i < 300 && e_busy; i++) begin
      rd_addr = AW'($urandom());
      if (alt) rd_req = (i % 2 == 0);
      else if (stall_after >= 0) begin
        rd_req = (waddrs.size() == stall_after && stalls < 3);
        if (rd_req) stalls++;
      end else rd_req = ($urandom_range(0, 99) < rd_pct);
      start = poke && (i == 3 || i == 6);
      step();
    end
    rd_req = 1'b0; start = 1'b0;
    if (e_busy) chk("burst_timeout", 64'(busy), 64'(0));
    repeat (3) step();
    alt_mode = 1'b0;
  endtask

  task automatic chk_seq(input string name, input logic [AW-1:0] b);
    chk({name, "_count"}, 64'(waddrs.size()), 64'(N));
    for (int i = 0; i < waddrs.size() && i < N; i++)
      chk({name, "_addr"}, 64'(waddrs[i]), 64'(AW'(b + AW'(i))));
    chk({name, "_done_cnt"}, 64'(done_cnt), 64'(1));
  endtask

  initial begin
    logic [AW-1:0] wrap_exp [N];
    #2;
    do_reset();

    // Baseline burst
    rand_table();
    tbl[0] = {6'b0, 10'd100, 10'd100, 10'h3FC};
    burst(19'h00100, 0, 1'b0, 1'b0, -1);
    chk_seq("base", 19'h00100);
    chk("base_latency", 64'(done_cyc - start_cyc), 64'(11));
    chk("base_wdata0", 64'(first_wdata), 64'h0_0641_93FC);
    chk("base_data_lag", 64'(first_drive_cyc - first_addr_cyc), 64'(2));

    // Three reads after index 3 issues
    rand_table();
    burst(19'h00100, 0, 1'b0, 1'b0, 4);
    chk_seq("stall", 19'h00100);
    chk("stall_latency", 64'(done_cyc - start_cyc), 64'(14));
    chk("stall_reads", 64'(rv_cnt), 64'(3));

    // Start pulses while busy
    rand_table();
    burst(19'h00200, 0, 1'b0, 1'b1, -1);
    chk_seq("poke", 19'h00200);

    // Address wrap
    wrap_exp = '{19'h7FFFE, 19'h7FFFF, 19'h00000, 19'h00001,
                 19'h00002, 19'h00003, 19'h00004, 19'h00005};
    burst(19'h7FFFE, 0, 1'b0, 1'b0, -1);
    chk("wrap_count", 64'(waddrs.size()), 64'(N));
    for (int i = 0; i < waddrs.size() && i < N; i++)
      chk("wrap_addr", 64'(waddrs[i]), 64'(wrap_exp[i]));

    // Reset after the 4th write issue, then a clean burst
    rand_table();
    clear_obs();
    base_addr = 19'h00300; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 50 && waddrs.size() < 4; i++) step();
    chk("pre_reset_writes", 64'(waddrs.size()), 64'(4));
    do_reset();
    clear_obs();
    repeat (6) step();
    chk("post_reset_drive", 64'(first_drive_cyc), 64'(-1));
    chk("post_reset_done", 64'(done_cnt), 64'(0));
    burst(19'h00300, 0, 1'b0, 1'b0, -1);
    chk_seq("after_rst", 19'h00300);

    // Alternating reads and writes
    rand_table();
    burst(19'h00040, 0, 1'b1, 1'b0, -1);
    chk_seq("alt", 19'h00040);
    chk("alt_reads", 64'(rv_cnt >= N), 64'(1));

    // Randomized bursts with random contention and stray starts
    for (int k = 0; k < 12; k++) begin
      logic [AW-1:0] rb;
      rand_table();
      rb = AW'($urandom());
      burst(rb, int'($urandom_range(0, 70)), 1'b0, k[0], -1);
      chk_seq("rand", rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/zbt_point_writer.md
Name: zbt_point_writer

Overview:
- Sequences a burst of point records (36-bit: 6'b0, x[9:0], y[9:0], colour[9:0]) from the combinational point table into ZBT SRAM, one write per free cycle.
- Shares the single ZBT port with the display read path: reads always win a cycle and the write burst stalls.
- Sits between the point table, the display fetch logic and the ZBT pin driver. It owns the ZBT address and control and models the 2-cycle ZBT pipeline.

Parameters:
- N_ENTRIES, 8, records per burst (1..8); the table index is 3 bits.
- AW, 19, ZBT address width.
- DW, 36, ZBT data width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a burst; ignored while busy.
- base_addr  in  AW  ZBT address of record 0; sampled on accepted start.
- busy  out  1  high from the cycle after an accepted start through the done cycle.
- done  out  1  one-cycle pulse when the last write data has been driven.
- tbl_index  out  3  index to the point table.
- tbl_value  in  DW  table output; combinational from tbl_index, same cycle.
- rd_req  in  1  display read request, level.
- rd_addr  in  AW  display read address.
- rd_grant  out  1  combinational; high when rd_req is serviced this cycle.
- rd_valid  out  1  read data valid, 2 cycles after grant.
- rd_data  out  DW  registered capture of zbt_rdata, valid with rd_valid.
- zbt_addr  out  AW  ZBT address, registered.
- zbt_we_n  out  1  ZBT write enable, active-low, registered.
- zbt_wdata  out  DW  write data, driven 2 cycles after its address cycle.
- zbt_drive  out  1  tristate enable for zbt_wdata; high exactly in write data cycles.
- zbt_rdata  in  DW  ZBT read data bus.

Behaviour:
- Reset (async, reset_n=0): FSM=IDLE, idx=0, busy=0, done=0, zbt_we_n=1, zbt_addr=0, zbt_wdata=0, zbt_drive=0, rd_valid=0, rd_data=0, and all pipeline stages cleared.
- Reset mid-burst aborts the burst. No done pulse is produced and no write data is driven afterwards.
- FSM states:
  - IDLE: start=1 latches base_addr, sets idx=0 and goes to WRITE.
  - WRITE: issues records; when the last record issues, goes to DRAIN with drain count 2.
  - DRAIN: waits 2 cycles for the write data pipeline to empty, then goes to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Arbitration per cycle:
  - rd_req=1 gives the cycle to the read: rd_grant=1, zbt_addr<=rd_addr, zbt_we_n<=1.
  - A read in WRITE state stalls idx; the stall is unbounded while rd_req is held.
  - Reads are granted in every state, including DRAIN and DONE.
- Write slot (WRITE state and rd_req=0):
  - tbl_index=idx. zbt_addr<=base+idx (mod 2^AW, wraps). zbt_we_n<=0.
  - tbl_value is captured into write pipe stage 1; idx increments.
  - The issue with idx=N_ENTRIES-1 is the last one.
- Write data pipeline: stage1 -> stage2 -> zbt_wdata. zbt_drive=1 in the cycle two clocks after the address cycle (when zbt_we_n was sampled low); otherwise 0 and zbt_wdata holds.
- Read pipeline: a grant in cycle n raises rd_valid in cycle n+2, with rd_data<=zbt_rdata registered at the n+2 edge.
- Reads and writes may interleave back-to-back. Write data cycles never collide with read data cycles because each address cycle owns exactly one data cycle.
- tbl_index outputs idx in all states (0 in IDLE).
- Latency: with no reads, start in cycle 0 gives address cycles 1..N, last data at N+2, done at N+3, busy low at N+4.

Test Plan:
- No contention, base=0x00100, start: 8 writes to addresses 0x00100..0x00107 in consecutive cycles. Write data for index 0 = {6'b0,10'd100,10'd100,10'h3FC} driven 2 cycles after its address. done pulses once; total 11 cycles from start to done.
- rd_req held for 3 cycles in the middle of the burst (after index 3 issues): idx stalls at 4 and 3 reads are granted. Each read's rd_valid appears 2 cycles after its grant and rd_data matches the zbt_rdata model. The burst completes 3 cycles later than the baseline with addresses unchanged.
- start pulsed while busy: no restart, addresses unaffected, exactly one done.
- base_addr=0x7FFFE: write addresses are 0x7FFFE, 0x7FFFF, 0x00000..0x00005 (wrap).
- reset_n asserted after the 4th write issue: all outputs return to reset values immediately. No zbt_drive, no done. A new start then performs a full 8-record burst.
- Alternating rd_req (1,0,1,0…): writes occupy the odd slots and zbt_drive never coincides with rd_valid capture of the same slot. All 8 records land correctly.
